bullet_controller: RTL and testbench
====================================

# bullet_controller

Per-tank projectile engine feeding `color_mapper`'s bullet inputs. It accepts a fire request from the tank's control logic and spawns a bullet at the barrel tip. Once per video frame it advances three bullet slots in Q10.4 fixed point, reflecting or killing them at playfield edges and retiring them after a fixed lifetime. Its outputs drive `BulletNX/BulletNY/BulletNS/is_bulletN_active` directly.

## Interface
Parameters:
- `PF_XMIN` 10'd0 — left playfield edge, pixels
- `PF_XMAX` 10'd639 — right edge
- `PF_YMIN` 10'd0 — top edge
- `PF_YMAX` 10'd479 — bottom edge
- `SPEED` 4'd2 — pixels/frame at unit direction
- `BARREL` 6'd12 — spawn offset from tank centre, pixels
- `LIFETIME` 10'd600 — frames a bullet lives
- `COOLDOWN` 6'd15 — frames between accepted shots
- `BULLET_SIZE` 10'd2 — half-size driven on `BulletNS`

Ports:
- `CLK` in 1 — system clock. All logic is single-clock.
- `Reset` in 1 — asynchronous, active-high.
- `frame_tick` in 1 — one-cycle pulse per frame (vsync edge, already synchronous).
- `fire` in 1 — level fire button; rising edge detected internally.
- `tank_dead` in 1 — owning tank destroyed; blocks new shots.
- `TankX`, `TankY` in 10 each — tank centre, pixels.
- `sin`, `cos` in 8 each — signed Q4.4 heading; 8'sd16 = 1.0.
- `Bullet1X..Bullet3X`, `Bullet1Y..Bullet3Y` out 10 each — integer pixel position.
- `Bullet1S..Bullet3S` out 10 each — constant `BULLET_SIZE`.
- `is_bullet1_active..is_bullet3_active` out 1 each.
- `shot_fired` out 1 — one-cycle pulse on a successful spawn.

## Operation
- Position is stored unsigned Q10.4 (14 bits); the output is bits [13:4].
- Velocity is stored signed Q8.4 (12 bits): `vx = cos*SPEED`, `vy = sin*SPEED`, full signed multiply, truncated to 12 bits.
- Fire edge sets `fire_pend`. The edge is ignored while `tank_dead`=1; `tank_dead`=1 also clears `fire_pend`.
- FSM states and transitions:
  - IDLE → UPD0 on `frame_tick`.
  - UPD0 → UPD1 → UPD2 → SPAWN → IDLE, one cycle each.
- UPDk, applied only if slot k is active:
  - `pos += sign-extended vel`.
  - Decrement `life`; on reaching 0, clear active.
  - Edge check per axis: if the new integer coordinate is < MIN or > MAX, clamp to that edge and handle per `BULLET_BOUNCE_EN`.
  - X and Y edge hits in the same step are both handled.
- SPAWN, if `fire_pend`, `cooldown`==0 and any slot is free:
  - Take the lowest-index free slot.
  - `pos = (Tank<<4) + dir*BARREL` (signed Q.4), clamped to the playfield.
  - Load vel, `life=LIFETIME`, `cooldown=COOLDOWN`; set active; pulse `shot_fired`.
- SPAWN always clears `fire_pend`. A request arriving with the pool full or cooldown running is dropped, not queued.
- `cooldown` decrements once per frame in SPAWN, before the spawn check, saturating at 0.
- Direction is sampled at spawn; later `sin`/`cos` changes do not steer bullets in flight.

## Timing
- Reset values:
  - all `is_bulletN_active`=0; X/Y=0; `BulletNS`=`BULLET_SIZE`; `shot_fired`=0
  - `fire_pend`=0; `cooldown`=0; state IDLE
- Outputs are registered and reflect slot k one cycle after UPDk.
- A spawned slot is visible the cycle after SPAWN, i.e. 5 cycles after `frame_tick`.
- A fire edge coincident with `frame_tick` is latched in that cycle and serviced in the same frame's SPAWN.
- A `frame_tick` arriving while not in IDLE is ignored; ticks are ≥800 cycles apart in practice.
- `Reset` mid-sequence aborts immediately; all slots go inactive.

## Configuration
- `BULLET_BOUNCE_EN` defined: on an edge hit, negate that axis velocity. The bullet stays active until its life expires.
- Undefined: an edge hit clears the slot's active bit in that UPD cycle; the velocity-negate logic is absent.

## Structure
- `tank_pkg` holds:
  - Q-format widths (`POS_W`=14, `VEL_W`=12, `FRAC`=4)
  - `NUM_BULLETS`=3
  - FSM enum `bc_state_t`
  - `bullet_t` struct {active, pos_x, pos_y, vel_x, vel_y, life}
- Sub-module `bullet_step`: combinational single-slot advance (add, edge clamp, bounce/kill, life decrement), instantiated once and muxed by slot index.

## Test plan
- Reset, then tank (320,240), cos=16, sin=0, fire edge, one tick.
  - `shot_fired` pulses; `Bullet1X`=332, `Bullet1Y`=240, `is_bullet1_active`=1.
  - After 10 further ticks, `Bullet1X`=352.
- Four fire edges spaced 20 frames apart.
  - Slots 1, 2, 3 fill in order; the 4th is dropped with no `shot_fired`.
- Two fire edges 5 frames apart.
  - Second is rejected by cooldown. A new edge 15 frames after the first spawns.
- Bullet at X=636 moving +2/frame, bounce enabled.
  - Clamps to 639; next frame X=637.
  - Without `BULLET_BOUNCE_EN`: inactive at the clamp frame.
- `LIFETIME`=3: spawn, then 3 ticks.
  - Active after ticks 1–2, inactive after tick 3.
  - Assert `Reset` during UPD1: all outputs return to reset values next cycle.
- `tank_dead`=1 with fire edges.
  - No spawn. Existing bullets keep moving.

Source files
------------

// File: rtl/tank_pkg.sv
// Shared types and fixed-point formats for the tank projectile logic.
// Positions are unsigned Q10.4, velocities signed Q8.4.
package tank_pkg;

  localparam int POS_W       = 14;  // unsigned Q10.4 position
  localparam int VEL_W       = 12;  // signed Q8.4 velocity
  localparam int FRAC        = 4;   // fractional bits in both formats
  localparam int PIX_W       = 10;  // integer pixel coordinate width
  localparam int LIFE_W      = 10;  // frame lifetime counter width
  localparam int CD_W        = 6;   // cooldown counter width
  localparam int SUM_W       = 18;  // signed headroom for position arithmetic
  localparam int NUM_BULLETS = 3;

  typedef enum logic [2:0] {
    BC_IDLE  = 3'd0,
    BC_UPD0  = 3'd1,
    BC_UPD1  = 3'd2,
    BC_UPD2  = 3'd3,
    BC_SPAWN = 3'd4
  } bc_state_t;

  typedef struct packed {
    logic                     active;
    logic [POS_W-1:0]         pos_x;
    logic [POS_W-1:0]         pos_y;
    logic signed [VEL_W-1:0]  vel_x;
    logic signed [VEL_W-1:0]  vel_y;
    logic [LIFE_W-1:0]        life;
  } bullet_t;

  // True when a signed Q.4 position has an integer part outside [lo, hi].
  function automatic logic out_of_range(input logic signed [SUM_W-1:0] p,
                                        input logic [PIX_W-1:0] lo,
                                        input logic [PIX_W-1:0] hi);
    logic signed [SUM_W-1:0] lo_q;
    logic signed [SUM_W-1:0] hi_q;
    lo_q = $signed({4'b0000, lo, 4'b0000});
    hi_q = $signed({4'b0000, hi, 4'b1111});
    return (p < lo_q) || (p > hi_q);
  endfunction

  // Clamp a signed Q.4 position onto the playfield; a clamped value lands
  // exactly on the edge pixel with zero fraction.
  function automatic logic [POS_W-1:0] clamp_pos(input logic signed [SUM_W-1:0] p,
                                                 input logic [PIX_W-1:0] lo,
                                                 input logic [PIX_W-1:0] hi);
    logic signed [SUM_W-1:0] lo_q;
    logic signed [SUM_W-1:0] hi_q;
    lo_q = $signed({4'b0000, lo, 4'b0000});
    hi_q = $signed({4'b0000, hi, 4'b1111});
    if (p < lo_q)      return {lo, 4'b0000};
    else if (p > hi_q) return {hi, 4'b0000};
    else               return p[POS_W-1:0];
  endfunction

endpackage

// File: rtl/bullet_step.sv
// Combinational one-frame advance of a single bullet slot: move, clamp at
// the playfield edges, bounce or kill, and age the slot.
// Build option: BULLET_BOUNCE_EN makes edge hits reflect instead of kill.
module bullet_step
  import tank_pkg::*;
#(
  parameter logic [9:0] PF_XMIN = 10'd0,
  parameter logic [9:0] PF_XMAX = 10'd639,
  parameter logic [9:0] PF_YMIN = 10'd0,
  parameter logic [9:0] PF_YMAX = 10'd479
) (
  input  bullet_t cur,
  output bullet_t nxt
);

  logic signed [SUM_W-1:0] sum_x;
  logic signed [SUM_W-1:0] sum_y;
  logic                    hit_x;
  logic                    hit_y;

  // Advance an active slot; an inactive slot passes through untouched.
  always_comb begin
    nxt   = cur;
    sum_x = $signed({4'b0000, cur.pos_x}) + $signed({{6{cur.vel_x[VEL_W-1]}}, cur.vel_x});
    sum_y = $signed({4'b0000, cur.pos_y}) + $signed({{6{cur.vel_y[VEL_W-1]}}, cur.vel_y});
    hit_x = out_of_range(sum_x, PF_XMIN, PF_XMAX);
    hit_y = out_of_range(sum_y, PF_YMIN, PF_YMAX);
    if (cur.active) begin
      nxt.pos_x = clamp_pos(sum_x, PF_XMIN, PF_XMAX);
      nxt.pos_y = clamp_pos(sum_y, PF_YMIN, PF_YMAX);
      nxt.life  = (cur.life == '0) ? '0 : cur.life - 1'b1;
      if (nxt.life == '0) nxt.active = 1'b0;
`ifdef BULLET_BOUNCE_EN
      // Reflect each axis that hit independently so corners bounce cleanly.
      if (hit_x) nxt.vel_x = -cur.vel_x;
      if (hit_y) nxt.vel_y = -cur.vel_y;
`else
      if (hit_x || hit_y) nxt.active = 1'b0;
`endif
    end
  end

endmodule

// File: rtl/bullet_controller.sv
// Per-tank projectile engine: three bullet slots advanced once per frame,
// spawned at the barrel tip on a fire edge, with cooldown and lifetime.
// Build option: BULLET_BOUNCE_EN (edge hits reflect instead of kill).
// Fire request: a rising edge of fire sets a pending flag that the next
// SPAWN state consumes; it is honoured only if cooldown has run out and a
// slot is free, otherwise it is dropped (never queued across frames).
module bullet_controller
  import tank_pkg::*;
#(
  parameter logic [9:0] PF_XMIN     = 10'd0,
  parameter logic [9:0] PF_XMAX     = 10'd639,
  parameter logic [9:0] PF_YMIN     = 10'd0,
  parameter logic [9:0] PF_YMAX     = 10'd479,
  parameter logic [3:0] SPEED       = 4'd2,
  parameter logic [5:0] BARREL      = 6'd12,
  parameter logic [9:0] LIFETIME    = 10'd600,
  parameter logic [5:0] COOLDOWN    = 6'd15,
  parameter logic [9:0] BULLET_SIZE = 10'd2
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              frame_tick,
  input  logic              fire,
  input  logic              tank_dead,
  input  logic [9:0]        TankX,
  input  logic [9:0]        TankY,
  input  logic signed [7:0] sin,
  input  logic signed [7:0] cos,
  output logic [9:0]        Bullet1X,
  output logic [9:0]        Bullet2X,
  output logic [9:0]        Bullet3X,
  output logic [9:0]        Bullet1Y,
  output logic [9:0]        Bullet2Y,
  output logic [9:0]        Bullet3Y,
  output logic [9:0]        Bullet1S,
  output logic [9:0]        Bullet2S,
  output logic [9:0]        Bullet3S,
  output logic              is_bullet1_active,
  output logic              is_bullet2_active,
  output logic              is_bullet3_active,
  output logic              shot_fired,
  output bc_state_t         dbg_state
);

  bc_state_t        state;
  bc_state_t        next_state;
  bullet_t          slot [NUM_BULLETS];
  bullet_t          step_in;
  bullet_t          step_out;
  bullet_t          spawn_b;
  logic             fire_q;
  logic             fire_edge;
  logic             fire_pend;
  logic [CD_W-1:0]  cooldown;
  logic [CD_W-1:0]  cd_dec;
  logic             any_free;
  logic [1:0]       free_idx;
  logic             spawn_ok;
  logic signed [14:0]      off_x;
  logic signed [14:0]      off_y;
  logic signed [12:0]      vx_full;
  logic signed [12:0]      vy_full;
  logic signed [SUM_W-1:0] sx;
  logic signed [SUM_W-1:0] sy;

  assign fire_edge = fire & ~fire_q;
  assign dbg_state = state;

  // Frame sequencer state register.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) state <= BC_IDLE;
    else       state <= next_state;
  end

  // One frame = three slot updates then a spawn opportunity; ticks that
  // arrive mid-sequence are ignored.
  always_comb begin
    next_state = state;
    case (state)
      BC_IDLE:  if (frame_tick) next_state = BC_UPD0;
      BC_UPD0:  next_state = BC_UPD1;
      BC_UPD1:  next_state = BC_UPD2;
      BC_UPD2:  next_state = BC_SPAWN;
      BC_SPAWN: next_state = BC_IDLE;
      default:  next_state = BC_IDLE;
    endcase
  end

  // Route the slot being updated this cycle through the shared stepper.
  always_comb begin
    step_in = slot[0];
    case (state)
      BC_UPD1: step_in = slot[1];
      BC_UPD2: step_in = slot[2];
      default: step_in = slot[0];
    endcase
  end

  bullet_step #(
    .PF_XMIN (PF_XMIN),
    .PF_XMAX (PF_XMAX),
    .PF_YMIN (PF_YMIN),
    .PF_YMAX (PF_YMAX)
  ) u_step (
    .cur (step_in),
    .nxt (step_out)
  );

  // Lowest-index free slot wins.
  always_comb begin
    any_free = 1'b0;
    free_idx = 2'd0;
    for (int i = NUM_BULLETS - 1; i >= 0; i--) begin
      if (!slot[i].active) begin
        any_free = 1'b1;
        free_idx = 2'(i);
      end
    end
  end

  // Spawn geometry: barrel tip in Q.4, velocity from the sampled heading.
  always_comb begin
    off_x   = cos * $signed({1'b0, BARREL});
    off_y   = sin * $signed({1'b0, BARREL});
    vx_full = cos * $signed({1'b0, SPEED});
    vy_full = sin * $signed({1'b0, SPEED});
    sx      = $signed({4'b0000, TankX, 4'b0000}) + $signed({{3{off_x[14]}}, off_x});
    sy      = $signed({4'b0000, TankY, 4'b0000}) + $signed({{3{off_y[14]}}, off_y});
    spawn_b        = '0;
    spawn_b.active = 1'b1;
    spawn_b.pos_x  = clamp_pos(sx, PF_XMIN, PF_XMAX);
    spawn_b.pos_y  = clamp_pos(sy, PF_YMIN, PF_YMAX);
    spawn_b.vel_x  = vx_full[VEL_W-1:0];
    spawn_b.vel_y  = vy_full[VEL_W-1:0];
    spawn_b.life   = LIFETIME;
    cd_dec   = (cooldown == '0) ? '0 : cooldown - 1'b1;
    spawn_ok = (state == BC_SPAWN) && fire_pend && (cd_dec == '0) && any_free;
  end

  // Fire edge capture, cooldown, slot updates and spawn.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      fire_q     <= 1'b0;
      fire_pend  <= 1'b0;
      cooldown   <= '0;
      shot_fired <= 1'b0;
      for (int i = 0; i < NUM_BULLETS; i++) slot[i] <= '0;
    end else begin
      fire_q     <= fire;
      shot_fired <= spawn_ok;
      // A fresh edge in the SPAWN cycle survives into the next frame.
      if (tank_dead)               fire_pend <= 1'b0;
      else if (fire_edge)          fire_pend <= 1'b1;
      else if (state == BC_SPAWN)  fire_pend <= 1'b0;
      case (state)
        BC_UPD0: slot[0] <= step_out;
        BC_UPD1: slot[1] <= step_out;
        BC_UPD2: slot[2] <= step_out;
        BC_SPAWN: begin
          cooldown <= spawn_ok ? COOLDOWN : cd_dec;
          for (int i = 0; i < NUM_BULLETS; i++) begin
            if (spawn_ok && (free_idx == 2'(i))) slot[i] <= spawn_b;
          end
        end
        default: ;
      endcase
    end
  end

  assign Bullet1X = slot[0].pos_x[POS_W-1:FRAC];
  assign Bullet2X = slot[1].pos_x[POS_W-1:FRAC];
  assign Bullet3X = slot[2].pos_x[POS_W-1:FRAC];
  assign Bullet1Y = slot[0].pos_y[POS_W-1:FRAC];
  assign Bullet2Y = slot[1].pos_y[POS_W-1:FRAC];
  assign Bullet3Y = slot[2].pos_y[POS_W-1:FRAC];
  assign Bullet1S = BULLET_SIZE;
  assign Bullet2S = BULLET_SIZE;
  assign Bullet3S = BULLET_SIZE;
  assign is_bullet1_active = slot[0].active;
  assign is_bullet2_active = slot[1].active;
  assign is_bullet3_active = slot[2].active;

endmodule

// File: tb/tb_bullet_controller.sv
// Directed bench for bullet_controller; a second instance runs with a
// three-frame lifetime to exercise expiry alongside the default build.
module tb_bullet_controller;
  import tank_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst = 1'b1;
  logic              frame_tick = 1'b0;
  logic              fire = 1'b0;
  logic              tank_dead = 1'b0;
  logic [9:0]        tank_x = 10'd0;
  logic [9:0]        tank_y = 10'd0;
  logic signed [7:0] sin_v = 8'sd0;
  logic signed [7:0] cos_v = 8'sd0;

  logic [9:0] b1x, b2x, b3x, b1y, b2y, b3y, b1s, b2s, b3s;
  logic       a1, a2, a3, shot;
  bc_state_t  st;

  logic [9:0] l1x, l2x, l3x, l1y, l2y, l3y, l1s, l2s, l3s;
  logic       la1, la2, la3, lshot;
  bc_state_t  lst;

  bullet_controller dut (
    .CLK(clk), .Reset(rst), .frame_tick(frame_tick), .fire(fire),
    .tank_dead(tank_dead), .TankX(tank_x), .TankY(tank_y),
    .sin(sin_v), .cos(cos_v),
    .Bullet1X(b1x), .Bullet2X(b2x), .Bullet3X(b3x),
    .Bullet1Y(b1y), .Bullet2Y(b2y), .Bullet3Y(b3y),
    .Bullet1S(b1s), .Bullet2S(b2s), .Bullet3S(b3s),
    .is_bullet1_active(a1), .is_bullet2_active(a2), .is_bullet3_active(a3),
    .shot_fired(shot), .dbg_state(st)
  );

  bullet_controller #(.LIFETIME(10'd3)) dut_l (
    .CLK(clk), .Reset(rst), .frame_tick(frame_tick), .fire(fire),
    .tank_dead(tank_dead), .TankX(tank_x), .TankY(tank_y),
    .sin(sin_v), .cos(cos_v),
    .Bullet1X(l1x), .Bullet2X(l2x), .Bullet3X(l3x),
    .Bullet1Y(l1y), .Bullet2Y(l2y), .Bullet3Y(l3y),
    .Bullet1S(l1s), .Bullet2S(l2s), .Bullet3S(l3s),
    .is_bullet1_active(la1), .is_bullet2_active(la2), .is_bullet3_active(la3),
    .shot_fired(lshot), .dbg_state(lst)
  );

  // ---------------- scoreboard ----------------
  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  logic        shot_seen;
  int          shot_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; fire = 1'b0; frame_tick = 1'b0; tank_dead = 1'b0;
    step(); step();
    rst = 1'b0;
    step();
  endtask

  task automatic fire_edge();
    fire = 1'b1; step();
    fire = 1'b0; step();
  endtask

  // One frame: pulse frame_tick (optionally with a coincident fire edge),
  // then let the sequence finish and note any shot_fired pulse.
  task automatic do_tick(input logic with_fire);
    frame_tick = 1'b1;
    fire = with_fire;
    step();
    frame_tick = 1'b0;
    fire = 1'b0;
    shot_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (shot === 1'b1) shot_seen = 1'b1;
    end
    if (shot_seen) shot_cnt++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) do_tick(1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    shot_seen = 1'b0;
    shot_cnt = 0;
    do_reset();

    // Reset values
    check("rst_active1", {29'd0, a1, a2, a3}, 32'd0);
    check("rst_x1", b1x, 32'd0);
    check("rst_y3", b3y, 32'd0);
    check("rst_size", {2'd0, b1s, b2s, b3s}, {2'd0, 10'd2, 10'd2, 10'd2});
    check("rst_shot", shot, 32'd0);
    check("rst_state", st, BC_IDLE);

    // Basic spawn and flight to the right
    tank_x = 10'd320; tank_y = 10'd240; cos_v = 8'sd16; sin_v = 8'sd0;
    fire_edge();
    do_tick(1'b0);
    check("spawn_shot", shot_seen, 32'd1);
    check("spawn_x", b1x, 32'd332);
    check("spawn_y", b1y, 32'd240);
    check("spawn_active", {a1, a2, a3}, 32'b100);
    check("spawn_l_active", la1, 32'd1);
    for (int k = 1; k <= 10; k++) exp_q.push_back(32'(332 + 2 * k));
    for (int k = 1; k <= 10; k++) begin
      do_tick(1'b0);
      check("fly_x", b1x, exp_q.pop_front());
      if (k == 1) check("life_t1", la1, 32'd1);
      if (k == 2) check("life_t2", la1, 32'd1);
      if (k == 3) check("life_t3", la1, 32'd0);
    end
    check("fly_y", b1y, 32'd240);

    // Pool fill: three edges fill slots in order, the fourth is dropped
    do_reset();
    tank_x = 10'd100; tank_y = 10'd100; cos_v = 8'sd0; sin_v = 8'sd16;
    fire_edge(); do_tick(1'b0);
    check("pool1_shot", shot_seen, 32'd1);
    check("pool1_act", {a1, a2, a3}, 32'b100);
    check("pool1_y", b1y, 32'd112);
    ticks(19);
    fire_edge(); do_tick(1'b0);
    check("pool2_shot", shot_seen, 32'd1);
    check("pool2_act", {a1, a2, a3}, 32'b110);
    check("pool2_y2", b2y, 32'd112);
    check("pool2_y1", b1y, 32'd152);
    ticks(19);
    fire_edge(); do_tick(1'b0);
    check("pool3_shot", shot_seen, 32'd1);
    check("pool3_act", {a1, a2, a3}, 32'b111);
    check("pool3_x3", b3x, 32'd100);
    ticks(19);
    fire_edge(); do_tick(1'b0);
    check("pool4_drop", shot_seen, 32'd0);
    check("pool4_act", {a1, a2, a3}, 32'b111);

    // Cooldown
    do_reset();
    tank_x = 10'd320; tank_y = 10'd240; cos_v = 8'sd16; sin_v = 8'sd0;
    fire_edge(); do_tick(1'b0);
    check("cd_first", shot_seen, 32'd1);
    ticks(4);
    fire_edge(); do_tick(1'b0);
    check("cd_reject", shot_seen, 32'd0);
    check("cd_reject_act", a2, 32'd0);
    shot_cnt = 0;
    ticks(9);
    check("cd_not_queued", shot_cnt, 32'd0);
    fire_edge(); do_tick(1'b0);
    check("cd_expired", shot_seen, 32'd1);
    check("cd_expired_act", a2, 32'd1);

    // Right edge, with fire coincident with the frame tick
    do_reset();
    tank_x = 10'd624; tank_y = 10'd240; cos_v = 8'sd16; sin_v = 8'sd0;
    do_tick(1'b1);
    check("edge_coinc_shot", shot_seen, 32'd1);
    check("edge_spawn_x", b1x, 32'd636);
    do_tick(1'b0);
    check("edge_x638", b1x, 32'd638);
    do_tick(1'b0);
    check("edge_clamp_x", b1x, 32'd639);
`ifdef BULLET_BOUNCE_EN
    check("edge_bounce_act", a1, 32'd1);
    do_tick(1'b0);
    check("edge_bounce_x", b1x, 32'd637);
`else
    check("edge_kill_act", a1, 32'd0);
`endif

    // Spawn clamp at the top-left corner, then a two-axis edge hit
    do_reset();
    tank_x = 10'd5; tank_y = 10'd5; cos_v = -8'sd16; sin_v = -8'sd16;
    fire_edge(); do_tick(1'b0);
    check("corner_spawn", {b1x, b1y}, 32'd0);
    check("corner_act", a1, 32'd1);
    do_tick(1'b0);
`ifdef BULLET_BOUNCE_EN
    check("corner_bounce_act", a1, 32'd1);
    do_tick(1'b0);
    check("corner_bounce_xy", {b1x, b1y}, {12'd0, 10'd2, 10'd2});
`else
    check("corner_kill_act", a1, 32'd0);
`endif

    // Dead tank blocks shots, existing bullet keeps moving
    do_reset();
    tank_x = 10'd320; tank_y = 10'd240; cos_v = 8'sd16; sin_v = 8'sd0;
    fire_edge(); do_tick(1'b0);
    check("dead_pre_x", b1x, 32'd332);
    tank_dead = 1'b1;
    fire_edge(); do_tick(1'b0);
    check("dead_no_shot", shot_seen, 32'd0);
    check("dead_move_x", b1x, 32'd334);
    check("dead_act2", a2, 32'd0);
    do_tick(1'b1);
    check("dead_coinc_no_shot", shot_seen, 32'd0);
    tank_dead = 1'b0;
    do_tick(1'b0);
    check("dead_pend_cleared", shot_seen, 32'd0);
    check("dead_move_x2", b1x, 32'd338);

    // Reset mid-sequence
    frame_tick = 1'b1; step();
    frame_tick = 1'b0;
    check("midrst_upd0", st, BC_UPD0);
    step();
    check("midrst_upd1", st, BC_UPD1);
    rst = 1'b1;
    #2;
    check("midrst_act", {a1, a2, a3}, 32'd0);
    check("midrst_x", b1x, 32'd0);
    check("midrst_size", b1s, 32'd2);
    check("midrst_shot", shot, 32'd0);
    check("midrst_state", st, BC_IDLE);
    step();
    rst = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard bound on the run in case anything stalls.
  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
